// File: rtl/cpu_axi_bridge_pkg.sv
// Shared definitions for the sram-like to AXI3 bridge: FSM states,
// default transaction ids, AXI tie-off values and the size mapping.
package cpu_axi_bridge_pkg;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_AR   = 2'd1,
    R_DATA = 2'd2
  } readState_e;

  typedef enum logic [1:0] {
    W_IDLE      = 2'd0,
    W_ADDR_DATA = 2'd1,
    W_RESP      = 2'd2
  } writeState_e;

  localparam logic [3:0] INST_ID_DEFAULT = 4'd0;
  localparam logic [3:0] DATA_ID_DEFAULT = 4'd1;

  // Every transfer is a single-beat INCR burst, normal/unprotected access.
  localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_LOCK_NONE  = 2'b00;
  localparam logic [3:0] AXI_CACHE_NONE = 4'b0000;
  localparam logic [2:0] AXI_PROT_NONE  = 3'b000;

  // sram size code 0/1/2 already equals log2(bytes), so AxSIZE just widens it.
  function automatic logic [2:0] sramSizeToAxi(input logic [1:0] size);
    return {1'b0, size};
  endfunction

endpackage

// File: rtl/cpu_axi_bridge_write_ch.sv
// Write channel engine: one single-beat write at a time, AW and W issued
// together and retired independently, then waits for the B response.
module axi_write_ch
  import cpu_axi_bridge_pkg::*;
#(
  parameter logic [3:0] ID = DATA_ID_DEFAULT
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start_i,
  input  logic [31:0] addr_i,
  input  logic [1:0]  size_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  wstrb_i,
  input  logic        awready_i,
  input  logic        wready_i,
  input  logic        bvalid_i,
  output logic [3:0]  awid_o,
  output logic [31:0] awaddr_o,
  output logic [2:0]  awsize_o,
  output logic        awvalid_o,
  output logic [3:0]  wid_o,
  output logic [31:0] wdata_o,
  output logic [3:0]  wstrb_o,
  output logic        wvalid_o,
  output logic        wlast_o,
  output logic        bready_o,
  output logic        idle_o,
  output logic        done_o
);

  writeState_e state_q, state_d;
  logic        awPend_q, awPend_d;
  logic        wPend_q, wPend_d;
  logic [3:0]  id_q, id_d;
  logic [31:0] awaddr_q, awaddr_d;
  logic [2:0]  awsize_q, awsize_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        wlast_q, wlast_d;

  // State and latched write fields; reset aborts any write with valids low.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= W_IDLE;
      awPend_q <= 1'b0;
      wPend_q  <= 1'b0;
      id_q     <= '0;
      awaddr_q <= '0;
      awsize_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      wlast_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      awPend_q <= awPend_d;
      wPend_q  <= wPend_d;
      id_q     <= id_d;
      awaddr_q <= awaddr_d;
      awsize_q <= awsize_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      wlast_q  <= wlast_d;
    end
  end

  // Next state: each of AW and W clears its own pending flag on handshake.
  always_comb begin
    state_d  = state_q;
    awPend_d = awPend_q;
    wPend_d  = wPend_q;
    id_d     = id_q;
    awaddr_d = awaddr_q;
    awsize_d = awsize_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    wlast_d  = wlast_q;
    done_o   = 1'b0;
    case (state_q)
      W_IDLE: begin
        if (start_i) begin
          awPend_d = 1'b1;
          wPend_d  = 1'b1;
          id_d     = ID;
          awaddr_d = addr_i;
          awsize_d = sramSizeToAxi(size_i);
          wdata_d  = wdata_i;
          wstrb_d  = wstrb_i;
          wlast_d  = 1'b1;
          state_d  = W_ADDR_DATA;
        end
      end
      W_ADDR_DATA: begin
        awPend_d = awPend_q & ~awready_i;
        wPend_d  = wPend_q & ~wready_i;
        if (!awPend_d && !wPend_d) state_d = W_RESP;
      end
      W_RESP: begin
        if (bvalid_i) begin
          done_o  = 1'b1;
          state_d = W_IDLE;
        end
      end
      default: state_d = W_IDLE;
    endcase
  end

  assign awvalid_o = awPend_q;
  assign wvalid_o  = wPend_q;
  assign bready_o  = (state_q == W_RESP);
  assign idle_o    = (state_q == W_IDLE);
  assign awid_o    = id_q;
  assign wid_o     = id_q;
  assign awaddr_o  = awaddr_q;
  assign awsize_o  = awsize_q;
  assign wdata_o   = wdata_q;
  assign wstrb_o   = wstrb_q;
  assign wlast_o   = wlast_q;

endmodule

// File: rtl/cpu_axi_bridge.sv
// Bridges the CPU inst/data sram-like ports onto one AXI3 master with one
// outstanding read and one outstanding write; data reads win arbitration.
module cpu_axi_bridge
  import cpu_axi_bridge_pkg::*;
#(
  parameter logic [3:0] INST_ID = INST_ID_DEFAULT,
  parameter logic [3:0] DATA_ID = DATA_ID_DEFAULT
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [31:0] inst_sram_addr,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [31:0] data_sram_addr,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  readState_e  readState_q, readState_d;
  logic [31:0] araddr_q, araddr_d;
  logic [2:0]  arsize_q, arsize_d;
  logic [3:0]  arid_q, arid_d;

  logic dataRdReq, writeIdle, writeDone, dataWrAccept;
  logic instAccept, dataRdAccept, instRspOk, dataRspOk;
  logic unusedInputs;

  assign dataRdReq = data_sram_req & ~data_sram_wr;

  // A write may start unless a data read is in flight, keeping data-port order.
  assign dataWrAccept = data_sram_req & data_sram_wr & writeIdle &
                        ((readState_q == R_IDLE) || (arid_q == INST_ID));

  // Read state and the latched AR fields.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      readState_q <= R_IDLE;
      araddr_q    <= '0;
      arsize_q    <= '0;
      arid_q      <= '0;
    end else begin
      readState_q <= readState_d;
      araddr_q    <= araddr_d;
      arsize_q    <= arsize_d;
      arid_q      <= arid_d;
    end
  end

  // Read arbitration and sequencing; data reads wait for the write side to idle.
  always_comb begin
    readState_d  = readState_q;
    araddr_d     = araddr_q;
    arsize_d     = arsize_q;
    arid_d       = arid_q;
    instAccept   = 1'b0;
    dataRdAccept = 1'b0;
    instRspOk    = 1'b0;
    dataRspOk    = 1'b0;
    case (readState_q)
      R_IDLE: begin
        if (dataRdReq && writeIdle) begin
          dataRdAccept = 1'b1;
          araddr_d     = data_sram_addr;
          arsize_d     = sramSizeToAxi(data_sram_size);
          arid_d       = DATA_ID;
          readState_d  = R_AR;
        end else if (inst_sram_req) begin
          instAccept  = 1'b1;
          araddr_d    = inst_sram_addr;
          arsize_d    = sramSizeToAxi(inst_sram_size);
          arid_d      = INST_ID;
          readState_d = R_AR;
        end
      end
      R_AR: begin
        if (arready) readState_d = R_DATA;
      end
      R_DATA: begin
        if (rvalid) begin
          if (rid == INST_ID) instRspOk = 1'b1;
          else                dataRspOk = 1'b1;
          readState_d = R_IDLE;
        end
      end
      default: readState_d = R_IDLE;
    endcase
  end

  axi_write_ch #(.ID(DATA_ID)) uWriteCh (
    .clk       (clk),
    .resetn    (resetn),
    .start_i   (dataWrAccept),
    .addr_i    (data_sram_addr),
    .size_i    (data_sram_size),
    .wdata_i   (data_sram_wdata),
    .wstrb_i   (data_sram_wstrb),
    .awready_i (awready),
    .wready_i  (wready),
    .bvalid_i  (bvalid),
    .awid_o    (awid),
    .awaddr_o  (awaddr),
    .awsize_o  (awsize),
    .awvalid_o (awvalid),
    .wid_o     (wid),
    .wdata_o   (wdata),
    .wstrb_o   (wstrb),
    .wvalid_o  (wvalid),
    .wlast_o   (wlast),
    .bready_o  (bready),
    .idle_o    (writeIdle),
    .done_o    (writeDone)
  );

  assign inst_sram_addr_ok = instAccept;
  assign data_sram_addr_ok = dataRdAccept | dataWrAccept;
  assign inst_sram_data_ok = instRspOk;
  assign data_sram_data_ok = dataRspOk | writeDone;
  assign inst_sram_rdata   = rdata;
  assign data_sram_rdata   = rdata;

  assign arid    = arid_q;
  assign araddr  = araddr_q;
  assign arsize  = arsize_q;
  assign arvalid = (readState_q == R_AR);
  assign rready  = (readState_q == R_DATA);

  assign arlen   = AXI_LEN_SINGLE;
  assign arburst = AXI_BURST_INCR;
  assign arlock  = AXI_LOCK_NONE;
  assign arcache = AXI_CACHE_NONE;
  assign arprot  = AXI_PROT_NONE;
  assign awlen   = AXI_LEN_SINGLE;
  assign awburst = AXI_BURST_INCR;
  assign awlock  = AXI_LOCK_NONE;
  assign awcache = AXI_CACHE_NONE;
  assign awprot  = AXI_PROT_NONE;

  // Inputs with no function here: inst writes, response codes, rlast, bid.
  assign unusedInputs = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata,
                          rresp, rlast, bid, bresp};

endmodule

// File: tb/tb_cpu_axi_bridge.sv
// Self-checking bench for cpu_axi_bridge: reset and arbitration table,
// directed multi-cycle sequences, then randomized traffic against a memory model.
module tb_cpu_axi_bridge;

  logic        clk;
  logic        resetn;
  logic        inst_sram_req, inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [31:0] inst_sram_addr, inst_sram_wdata;
  logic [3:0]  inst_sram_wstrb;
  logic        inst_sram_addr_ok, inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_req, data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic [3:0]  data_sram_wstrb;
  logic        data_sram_addr_ok, data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic [3:0]  arid, awid, wid, rid, bid;
  logic [31:0] araddr, awaddr, wdata, rdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize, arprot, awprot;
  logic [1:0]  arburst, arlock, awburst, awlock, rresp, bresp;
  logic [3:0]  arcache, awcache, wstrb;
  logic        arvalid, arready, rvalid, rready, rlast;
  logic        awvalid, awready, wvalid, wready, wlast;
  logic        bvalid, bready;

  int checks = 0;
  int failures = 0;

  logic [31:0] slaveMem [64];
  logic [31:0] refMem [64];
  logic [31:0] instReqAddr, dataReqAddr, dataReqWdata;
  logic [1:0]  instReqSize, dataReqSize;
  logic [3:0]  dataReqWstrb;
  bit          stopFlag;

  typedef struct {
    logic instReq;
    logic dataReq;
    logic dataWr;
    logic expInstOk;
    logic expDataOk;
  } arbVec_t;

  arbVec_t vecs [6];

  cpu_axi_bridge dut (
    .clk(clk), .resetn(resetn),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
    .inst_sram_size(inst_sram_size), .inst_sram_addr(inst_sram_addr),
    .inst_sram_wstrb(inst_sram_wstrb), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
    .data_sram_size(data_sram_size), .data_sram_addr(data_sram_addr),
    .data_sram_wstrb(data_sram_wstrb), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
    end
  endtask

  task automatic checkBit(input string name, input logic actual, input logic expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%b required=%b", name, actual, expected);
    end
  endtask

  function automatic int memIdx(input logic [31:0] a);
    return int'({a[15], a[6:2]});
  endfunction

  function automatic logic [31:0] mergeBytes(input logic [31:0] old, input logic [31:0] nw,
                                             input logic [3:0] strb);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  task automatic clearInputs();
    inst_sram_req = 0; inst_sram_wr = 0; inst_sram_size = 2'd2; inst_sram_addr = 0;
    inst_sram_wstrb = 0; inst_sram_wdata = 0;
    data_sram_req = 0; data_sram_wr = 0; data_sram_size = 2'd2; data_sram_addr = 0;
    data_sram_wstrb = 0; data_sram_wdata = 0;
    arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 0; rvalid = 0;
    awready = 0; wready = 0; bid = 0; bresp = 0; bvalid = 0;
  endtask

  task automatic resetDut();
    @(negedge clk);
    resetn = 1'b0;
    clearInputs();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic applyStimulus(input arbVec_t v);
    inst_sram_req  = v.instReq;
    inst_sram_addr = 32'h1c000000;
    data_sram_req  = v.dataReq;
    data_sram_wr   = v.dataWr;
    data_sram_addr = 32'h1c008000;
  endtask

  // Random CPU instruction fetcher: one request at a time, checks returned data.
  task automatic instAgent(input int n);
    int done = 0;
    bit busy = 0;
    bit fire = 0;
    logic [31:0] exp = 0;
    while (done < n && !stopFlag) begin
      @(negedge clk);
      if (fire) begin inst_sram_req = 0; busy = 1; fire = 0; end
      if (!busy && !inst_sram_req && $urandom_range(0, 3) == 0) begin
        inst_sram_req  = 1;
        inst_sram_size = 2'd2;
        inst_sram_addr = 32'h1c000000 + (32'($urandom_range(0, 31)) << 2);
      end
      #1;
      if (inst_sram_req && inst_sram_addr_ok) begin
        fire = 1;
        instReqAddr = inst_sram_addr;
        instReqSize = inst_sram_size;
        exp = refMem[memIdx(inst_sram_addr)];
      end
      if (inst_sram_data_ok) begin
        if (!busy) checkBit("instDataOkSpurious", inst_sram_data_ok, 1'b0);
        else begin
          checkOutput("instReadData", inst_sram_rdata, exp);
          busy = 0;
          done++;
        end
      end
    end
    inst_sram_req = 0;
  endtask

  // Random CPU data port: mixes reads and strobed writes in the data region.
  task automatic dataAgent(input int n);
    int done = 0;
    bit busy = 0;
    bit fire = 0;
    bit isWr = 0;
    logic [31:0] exp = 0;
    while (done < n && !stopFlag) begin
      @(negedge clk);
      if (fire) begin data_sram_req = 0; busy = 1; fire = 0; end
      if (!busy && !data_sram_req && $urandom_range(0, 2) == 0) begin
        data_sram_req   = 1;
        data_sram_wr    = 1'($urandom_range(0, 1));
        data_sram_size  = 2'($urandom_range(0, 2));
        data_sram_addr  = 32'h1c008000 + (32'($urandom_range(0, 15)) << 2);
        data_sram_wstrb = 4'($urandom_range(1, 15));
        data_sram_wdata = $urandom;
      end
      #1;
      if (data_sram_req && data_sram_addr_ok) begin
        fire = 1;
        isWr = data_sram_wr;
        dataReqAddr  = data_sram_addr;
        dataReqSize  = data_sram_size;
        dataReqWdata = data_sram_wdata;
        dataReqWstrb = data_sram_wstrb;
        if (isWr)
          refMem[memIdx(data_sram_addr)] = mergeBytes(refMem[memIdx(data_sram_addr)],
                                                      data_sram_wdata, data_sram_wstrb);
        else
          exp = refMem[memIdx(data_sram_addr)];
      end
      if (data_sram_data_ok) begin
        if (!busy) checkBit("dataDataOkSpurious", data_sram_data_ok, 1'b0);
        else begin
          if (!isWr) checkOutput("dataReadData", data_sram_rdata, exp);
          busy = 0;
          done++;
        end
      end
    end
    data_sram_req = 0;
  endtask

  // AXI slave with random ready/valid timing, backed by slaveMem.
  task automatic slaveAgent();
    logic [3:0]  rIdQ [$];
    logic [31:0] rAddrQ [$];
    bit rFire = 0, bFire = 0, awGot = 0, wGot = 0;
    logic [31:0] awA = 0, wD = 0;
    logic [3:0]  wS = 0;
    while (!stopFlag) begin
      @(negedge clk);
      if (rFire) begin rvalid = 0; rIdQ.delete(0); rAddrQ.delete(0); rFire = 0; end
      if (bFire) begin bvalid = 0; awGot = 0; wGot = 0; bFire = 0; end
      arready = ($urandom_range(0, 2) == 0);
      awready = ($urandom_range(0, 2) == 0);
      wready  = ($urandom_range(0, 2) == 0);
      if (!rvalid && rAddrQ.size() > 0 && $urandom_range(0, 1) == 0) begin
        rvalid = 1; rlast = 1; rresp = 0;
        rid    = rIdQ[0];
        rdata  = slaveMem[memIdx(rAddrQ[0])];
      end
      if (awGot && wGot && !bvalid && $urandom_range(0, 1) == 0) begin
        slaveMem[memIdx(awA)] = mergeBytes(slaveMem[memIdx(awA)], wD, wS);
        bvalid = 1; bid = 4'd1; bresp = 0;
      end
      #1;
      if (arvalid && arready) begin
        checkBit("arOneOutstanding", rAddrQ.size() == 0, 1'b1);
        if (arid == 4'd0) begin
          checkOutput("arAddrInst", araddr, instReqAddr);
          checkOutput("arSizeInst", 32'(arsize), {29'd0, 1'b0, instReqSize});
        end else begin
          checkOutput("arIdData", 32'(arid), 32'd1);
          checkOutput("arAddrData", araddr, dataReqAddr);
          checkOutput("arSizeData", 32'(arsize), {29'd0, 1'b0, dataReqSize});
        end
        rIdQ.push_back(arid);
        rAddrQ.push_back(araddr);
      end
      if (rvalid && rready) rFire = 1;
      if (awvalid && awready) begin
        checkBit("awOnce", awGot, 1'b0);
        checkOutput("awAddr", awaddr, dataReqAddr);
        checkOutput("awSize", 32'(awsize), {29'd0, 1'b0, dataReqSize});
        checkOutput("awId", 32'(awid), 32'd1);
        awGot = 1; awA = awaddr;
      end
      if (wvalid && wready) begin
        checkBit("wOnce", wGot, 1'b0);
        checkOutput("wData", wdata, dataReqWdata);
        checkOutput("wStrb", 32'(wstrb), 32'(dataReqWstrb));
        checkBit("wLast", wlast, 1'b1);
        wGot = 1; wD = wdata; wS = wstrb;
      end
      if (bvalid && bready) bFire = 1;
    end
    arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0;
  endtask

  initial begin
    vecs[0] = '{instReq: 0, dataReq: 0, dataWr: 0, expInstOk: 0, expDataOk: 0};
    vecs[1] = '{instReq: 1, dataReq: 0, dataWr: 0, expInstOk: 1, expDataOk: 0};
    vecs[2] = '{instReq: 0, dataReq: 1, dataWr: 0, expInstOk: 0, expDataOk: 1};
    vecs[3] = '{instReq: 1, dataReq: 1, dataWr: 0, expInstOk: 0, expDataOk: 1};
    vecs[4] = '{instReq: 0, dataReq: 1, dataWr: 1, expInstOk: 0, expDataOk: 1};
    vecs[5] = '{instReq: 1, dataReq: 1, dataWr: 1, expInstOk: 1, expDataOk: 1};
    for (int i = 0; i < 64; i++) begin
      slaveMem[i] = {8'hA5, 8'(i), 16'(i * 37 + 11)};
      refMem[i]   = slaveMem[i];
    end
    instReqAddr = 0; dataReqAddr = 0; dataReqWdata = 0;
    instReqSize = 0; dataReqSize = 0; dataReqWstrb = 0;
    stopFlag = 0;
    resetn = 1'b0;
    clearInputs();

    // Reset state
    #12;
    checkOutput("resetValids", 32'({arvalid, awvalid, wvalid, rready, bready}), 32'd0);
    checkOutput("resetAddrOk", 32'({inst_sram_addr_ok, data_sram_addr_ok}), 32'd0);
    checkOutput("resetAraddr", araddr, 32'd0);
    checkOutput("resetAwaddr", awaddr, 32'd0);
    checkOutput("tieArBurst", 32'(arburst), 32'd1);
    checkOutput("tieAwBurst", 32'(awburst), 32'd1);
    checkOutput("tieLenLock", 32'({arlen, awlen, arlock, awlock, arcache, awcache, arprot, awprot}), 32'd0);

    // Idle arbitration table, requests withdrawn before the clock edge
    resetDut();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkBit($sformatf("arbInstOk[%0d]", i), inst_sram_addr_ok, vecs[i].expInstOk);
      checkBit($sformatf("arbDataOk[%0d]", i), data_sram_addr_ok, vecs[i].expDataOk);
      clearInputs();
    end
    @(negedge clk);
    #1;
    checkBit("arbNoArvalid", arvalid, 1'b0);
    checkBit("arbNoAwvalid", awvalid, 1'b0);

    // Instruction read with delayed arready and rvalid
    resetDut();
    @(negedge clk);
    inst_sram_req = 1; inst_sram_addr = 32'h1c000000; inst_sram_size = 2'd2;
    #1 checkBit("ir_addrOk", inst_sram_addr_ok, 1'b1);
    checkBit("ir_arvalidPre", arvalid, 1'b0);
    @(negedge clk);
    inst_sram_req = 0;
    #1 checkBit("ir_arvalid1", arvalid, 1'b1);
    checkOutput("ir_araddr", araddr, 32'h1c000000);
    checkOutput("ir_arsize", 32'(arsize), 32'd2);
    checkOutput("ir_arid", 32'(arid), 32'd0);
    @(negedge clk);
    arready = 1;
    #1 checkBit("ir_arvalid2", arvalid, 1'b1);
    @(negedge clk);
    arready = 0;
    #1 checkBit("ir_arvalidDrop", arvalid, 1'b0);
    checkBit("ir_rready", rready, 1'b1);
    repeat (2) begin
      @(negedge clk);
      #1 checkBit("ir_noEarlyOk", inst_sram_data_ok, 1'b0);
    end
    @(negedge clk);
    rvalid = 1; rid = 4'd0; rdata = 32'h02800c0c; rlast = 1;
    #1 checkBit("ir_dataOk", inst_sram_data_ok, 1'b1);
    checkOutput("ir_rdata", inst_sram_rdata, 32'h02800c0c);
    checkBit("ir_dataPortQuiet", data_sram_data_ok, 1'b0);
    @(negedge clk);
    rvalid = 0; rlast = 0;
    #1 checkBit("ir_rreadyDrop", rready, 1'b0);
    checkBit("ir_dataOkPulse", inst_sram_data_ok, 1'b0);

    // Simultaneous inst and data read: data first, then inst
    resetDut();
    @(negedge clk);
    inst_sram_req = 1; inst_sram_addr = 32'h1c000040;
    data_sram_req = 1; data_sram_wr = 0; data_sram_addr = 32'h1c008000; data_sram_size = 2'd2;
    #1 checkBit("sim_dataFirst", data_sram_addr_ok, 1'b1);
    checkBit("sim_instHeld", inst_sram_addr_ok, 1'b0);
    @(negedge clk);
    data_sram_req = 0; arready = 1;
    #1 checkOutput("sim_aridData", 32'(arid), 32'd1);
    checkOutput("sim_araddrData", araddr, 32'h1c008000);
    checkBit("sim_instWaitAr", inst_sram_addr_ok, 1'b0);
    @(negedge clk);
    arready = 0; rvalid = 1; rid = 4'd1; rdata = 32'h11223344;
    #1 checkBit("sim_dataOk", data_sram_data_ok, 1'b1);
    checkOutput("sim_dataRdata", data_sram_rdata, 32'h11223344);
    checkBit("sim_instQuiet", inst_sram_data_ok, 1'b0);
    checkBit("sim_noSameCycle", inst_sram_addr_ok, 1'b0);
    @(negedge clk);
    rvalid = 0;
    #1 checkBit("sim_instAccept", inst_sram_addr_ok, 1'b1);
    @(negedge clk);
    inst_sram_req = 0; arready = 1;
    #1 checkOutput("sim_aridInst", 32'(arid), 32'd0);
    checkOutput("sim_araddrInst", araddr, 32'h1c000040);
    @(negedge clk);
    arready = 0; rvalid = 1; rid = 4'd0; rdata = 32'h55667788;
    #1 checkBit("sim_instDataOk", inst_sram_data_ok, 1'b1);
    checkBit("sim_dataPortQuiet", data_sram_data_ok, 1'b0);
    @(negedge clk);
    rvalid = 0;

    // Data write with AW and W accepted on different cycles
    resetDut();
    @(negedge clk);
    data_sram_req = 1; data_sram_wr = 1; data_sram_addr = 32'h1c008004; data_sram_size = 2'd1;
    data_sram_wstrb = 4'b0011; data_sram_wdata = 32'h0000beef;
    #1 checkBit("wr_addrOk", data_sram_addr_ok, 1'b1);
    @(negedge clk);
    data_sram_req = 0; awready = 1;
    #1 checkBit("wr_awvalid", awvalid, 1'b1);
    checkBit("wr_wvalid", wvalid, 1'b1);
    checkOutput("wr_awaddr", awaddr, 32'h1c008004);
    checkOutput("wr_awsize", 32'(awsize), 32'd1);
    checkOutput("wr_ids", 32'({awid, wid}), 32'h11);
    checkOutput("wr_wdata", wdata, 32'h0000beef);
    checkOutput("wr_wstrb", 32'(wstrb), 32'h3);
    checkBit("wr_wlast", wlast, 1'b1);
    @(negedge clk);
    awready = 0;
    #1 checkBit("wr_awDrop", awvalid, 1'b0);
    checkBit("wr_wHeld", wvalid, 1'b1);
    checkBit("wr_noBreadyYet", bready, 1'b0);
    @(negedge clk);
    wready = 1;
    #1 checkBit("wr_wStill", wvalid, 1'b1);
    @(negedge clk);
    wready = 0;
    #1 checkBit("wr_wDrop", wvalid, 1'b0);
    checkBit("wr_bready", bready, 1'b1);
    checkBit("wr_noEarlyOk", data_sram_data_ok, 1'b0);
    @(negedge clk);
    bvalid = 1; bid = 4'd1;
    #1 checkBit("wr_dataOk", data_sram_data_ok, 1'b1);
    @(negedge clk);
    bvalid = 0;
    #1 checkBit("wr_breadyDrop", bready, 1'b0);

    // Data read blocked while the write waits for its response
    resetDut();
    @(negedge clk);
    data_sram_req = 1; data_sram_wr = 1; data_sram_addr = 32'h1c008010;
    data_sram_wstrb = 4'hf; data_sram_wdata = 32'hcafef00d;
    #1 checkBit("raw_wrAccept", data_sram_addr_ok, 1'b1);
    @(negedge clk);
    data_sram_req = 0; awready = 1; wready = 1;
    @(negedge clk);
    awready = 0; wready = 0;
    data_sram_req = 1; data_sram_wr = 0; data_sram_addr = 32'h1c008008;
    #1 checkBit("raw_blocked1", data_sram_addr_ok, 1'b0);
    checkBit("raw_inResp", bready, 1'b1);
    @(negedge clk);
    #1 checkBit("raw_blocked2", data_sram_addr_ok, 1'b0);
    @(negedge clk);
    bvalid = 1; bid = 4'd1;
    #1 checkBit("raw_bDataOk", data_sram_data_ok, 1'b1);
    checkBit("raw_blockedOnB", data_sram_addr_ok, 1'b0);
    @(negedge clk);
    bvalid = 0;
    #1 checkBit("raw_readAccept", data_sram_addr_ok, 1'b1);
    @(negedge clk);
    data_sram_req = 0;
    #1 checkBit("raw_arvalid", arvalid, 1'b1);
    checkOutput("raw_araddr", araddr, 32'h1c008008);
    checkOutput("raw_arid", 32'(arid), 32'd1);

    // Reset asserted in the middle of R_DATA
    resetDut();
    @(negedge clk);
    inst_sram_req = 1; inst_sram_addr = 32'h1c000008;
    @(negedge clk);
    inst_sram_req = 0; arready = 1;
    @(negedge clk);
    arready = 0;
    #1 checkBit("rst_inRdata", rready, 1'b1);
    #1 resetn = 1'b0;
    #1 checkBit("rst_rreadyDrop", rready, 1'b0);
    checkBit("rst_arvalidLow", arvalid, 1'b0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    inst_sram_req = 1; inst_sram_addr = 32'h1c00000c;
    #1 checkBit("rst_freshAccept", inst_sram_addr_ok, 1'b1);
    checkBit("rst_noArvalid", arvalid, 1'b0);

    // Randomized traffic against the memory model
    resetDut();
    $display("[TB] starting random traffic");
    fork
      begin
        fork
          instAgent(40);
          dataAgent(60);
        join
        stopFlag = 1;
      end
      slaveAgent();
      begin
        for (int c = 0; c < 20000 && !stopFlag; c++) @(negedge clk);
        if (!stopFlag) begin
          checkBit("randomTimeout", 1'b1, 1'b0);
          stopFlag = 1;
        end
      end
    join

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
